// File: rtl/div_pkg.sv
// Shared definitions for the HI/LO divide sequencer.
// Provides the default width, FSM state encoding and count-width helper.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // Bits needed to count 0..w-1 restoring steps.
    function automatic int div_cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_FIXUP = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// Ports: rem_i/quo_i current partial remainder/quotient, dvs_i divisor,
//        rem_o/quo_o values after shift + trial subtract.
module div_step
#(
    parameter int WIDTH = 32
)
(
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           borrow;

    // Shifted remainder can exceed WIDTH bits, so subtract at WIDTH+1.
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_i};
    assign borrow  = diff[WIDTH];

    assign rem_o = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU engine holding the HI/LO result registers.
// Ports: clock, reset (async, active-high); start_E/signed_E/dividend_E/
//        divisor_E from execute; MfOpInD/HasDivD from decode; busy,
//        stall_div, done, div_hi (remainder), div_lo (quotient).
// Build option: DIV_EARLY_EXIT_EN skips iteration when |dvd| < |dvs|.
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start_E,
    input  logic             signed_E,
    input  logic [WIDTH-1:0] dividend_E,
    input  logic [WIDTH-1:0] divisor_E,
    input  logic             MfOpInD,
    input  logic             HasDivD,
    output logic             busy,
    output logic             stall_div,
    output logic             done,
    output logic [WIDTH-1:0] div_hi,
    output logic [WIDTH-1:0] div_lo
);

    localparam int CW = div_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_raw_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             neg_quo_q, neg_rem_q;
    logic             bypass_q, zdiv_q;
    logic             done_q;

    logic [WIDTH-1:0] dvd_abs, dvs_abs;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic             dvd_neg, dvs_neg;
    logic             zdiv_s, early_s;

    assign dvd_neg = signed_E & dividend_E[WIDTH-1];
    assign dvs_neg = signed_E & divisor_E[WIDTH-1];
    assign dvd_abs = dvd_neg ? -dividend_E : dividend_E;
    assign dvs_abs = dvs_neg ? -divisor_E : divisor_E;
    assign zdiv_s  = (divisor_E == '0);

`ifdef DIV_EARLY_EXIT_EN
    assign early_s = ~zdiv_s & (dvd_abs < dvs_abs);
`else
    assign early_s = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_nx),
        .quo_o (quo_nx)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a busy engine ignores start_E.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_E) begin
                    state_d = (zdiv_s | early_s) ? ST_FIXUP : ST_ITER;
                end
            end
            ST_ITER: begin
                if (count_q == LAST_STEP) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs; stall depends only on busy, never on start_E.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        stall_div = busy & (MfOpInD | HasDivD);
        done      = done_q;
        div_hi    = hi_q;
        div_lo    = lo_q;
    end

    // Datapath
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            dvd_raw_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bypass_q  <= 1'b0;
            zdiv_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_E) begin
                        count_q   <= '0;
                        rem_q     <= '0;
                        quo_q     <= dvd_abs;
                        dvs_q     <= dvs_abs;
                        dvd_raw_q <= dividend_E;
                        neg_quo_q <= dvd_neg ^ dvs_neg;
                        neg_rem_q <= dvd_neg;
                        bypass_q  <= zdiv_s | early_s;
                        zdiv_q    <= zdiv_s;
                    end
                end
                ST_ITER: begin
                    rem_q   <= rem_nx;
                    quo_q   <= quo_nx;
                    count_q <= count_q + CW'(1);
                end
                ST_FIXUP: begin
                    done_q <= 1'b1;
                    if (bypass_q) begin
                        // Zero divisor or trivially small dividend:
                        // remainder is the untouched operand.
                        hi_q <= dvd_raw_q;
                        lo_q <= zdiv_q ? '1 : '0;
                    end else begin
                        hi_q <= neg_rem_q ? -rem_q : rem_q;
                        lo_q <= neg_quo_q ? -quo_q : quo_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed divides, latency,
// busy/stall windows, divide-by-zero, overflow and async reset.
module tb_div_sequencer;

    logic        clock;
    logic        reset;
    logic        start_E;
    logic        signed_E;
    logic [31:0] dividend_E;
    logic [31:0] divisor_E;
    logic        MfOpInD;
    logic        HasDivD;
    logic        busy;
    logic        stall_div;
    logic        done;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    div_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .start_E    (start_E),
        .signed_E   (signed_E),
        .dividend_E (dividend_E),
        .divisor_E  (divisor_E),
        .MfOpInD    (MfOpInD),
        .HasDivD    (HasDivD),
        .busy       (busy),
        .stall_div  (stall_div),
        .done       (done),
        .div_hi     (div_hi),
        .div_lo     (div_lo)
    );

`ifdef DIV_EARLY_EXIT_EN
    localparam int LAT_SMALL = 2;
`else
    localparam int LAT_SMALL = 34;
`endif

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
        int          t0;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cmp  = 0;
    int   mism = 0;
    int   cyc  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            mism++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clock) begin
        if (!reset && done === 1'b1) begin
            if (q.size() == 0) begin
                cmp++;
                mism++;
                $display("FAIL unexpected_done: got done=1 expected 0");
            end else begin
                mon_e = q.pop_front();
                chk("div_lo", div_lo, mon_e.lo);
                chk("div_hi", div_hi, mon_e.hi);
                chk("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
            end
        end
    end

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic issue(input logic sg, input logic [31:0] dvd,
                         input logic [31:0] dvs, input logic [31:0] lo,
                         input logic [31:0] hi, input int lat);
        exp_t e;
        chk("start_while_busy", {31'b0, busy}, 32'd0);
        e.lo  = lo;
        e.hi  = hi;
        e.lat = lat;
        e.t0  = cyc;
        q.push_back(e);
        start_E    = 1'b1;
        signed_E   = sg;
        dividend_E = dvd;
        divisor_E  = dvs;
        @(negedge clock);
        start_E    = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && q.size() != 0; i++) @(negedge clock);
        if (q.size() != 0) begin
            cmp++;
            mism++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     q.size());
            q.delete();
        end
        @(negedge clock);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk("wait_done", {31'b0, done}, 32'd1);
    endtask

    int pulses;

    initial begin
        reset      = 1'b1;
        start_E    = 1'b0;
        signed_E   = 1'b0;
        dividend_E = '0;
        divisor_E  = '0;
        MfOpInD    = 1'b0;
        HasDivD    = 1'b0;
        @(negedge clock);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_stall", {31'b0, stall_div}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", div_hi, 32'd0);
        chk("rst_lo", div_lo, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // 1: DIVU 100/7 with busy window
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34);
        for (int k = 1; k <= 34; k++) begin
            chk($sformatf("busy_c%0d", k), {31'b0, busy}, 32'(k <= 33));
            @(negedge clock);
        end
        drain();

        // 2: signed, then back-to-back start on the done cycle
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
        wait_done();
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 34);
        drain();

        // 3: overflow and divide by zero
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34);
        drain();
        issue(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 2);
        drain();
        issue(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 2);
        drain();

        // 4: stall window for MfOpInD, then HasDivD
        for (int s = 0; s < 2; s++) begin
            issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34);
            MfOpInD = (s == 0);
            HasDivD = (s == 1);
            for (int k = 1; k <= 34; k++) begin
                #1;
                chk($sformatf("stall%0d_c%0d", s, k), {31'b0, stall_div},
                    32'(k <= 33));
                @(negedge clock);
            end
            MfOpInD = 1'b0;
            HasDivD = 1'b0;
            drain();
        end

        // 5: async reset in cycle 15
        issue(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 34);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        #1;
        q.delete();
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_hi", div_hi, 32'd0);
        chk("arst_lo", div_lo, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        @(negedge clock);
        reset  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done === 1'b1) pulses++;
        end
        chk("arst_no_done", 32'(pulses), 32'd0);
        issue(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34);
        drain();

        // 6: small dividend
        issue(1'b0, 32'd3, 32'd10, 32'd0, 32'd3, LAT_SMALL);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
